// File: rtl/neo_spike_detector.sv
// neo_spike_detector: calibrates a baseline from NEO energy, then flags samples above C x running mean
module neo_spike_detector #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int C = 4,
  parameter int R = 4,
  localparam int NW = 2 * N + 1,
  localparam int TW = NW + $clog2(C) + 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 neo_valid,
  input  logic signed [NW-1:0] neo_data,
  output logic                 out_valid,
  output logic                 spike,
  output logic [TW-1:0]        threshold,
  output logic                 calibrated,
  output logic [15:0]          spike_count
);
  localparam int LM = $clog2(M);
  localparam int SW = NW + LM;
  localparam int CW = (LM > $clog2(R + 1)) ? LM : $clog2(R + 1);
  typedef enum logic [1:0] {CALIB, DETECT, REFRACT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sum_q, sum_d, sum_nx;
  logic [NW-1:0] mean_q, mean_d, xc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] thr_q;
  logic out_valid_q, out_valid_d, spike_q, spike_d, cal_q, cal_d, hit;
  logic [15:0] sc_q, sc_d;
  logic signed [NW:0] diff, ema;
  assign xc     = neo_data[NW-1] ? '0 : neo_data;
  assign sum_nx = sum_q + SW'(xc);
  assign diff   = $signed({1'b0, xc}) - $signed({1'b0, mean_q});
  assign ema    = $signed({1'b0, mean_q}) + (diff >>> LM);
  assign hit    = TW'(xc) > thr_q;
  // next-state: calibration accumulate, detection with EMA tracking, refractory countdown
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    mean_d      = mean_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    spike_d     = spike_q;
    cal_d       = cal_q;
    sc_d        = sc_q;
    if (neo_valid) begin
      case (state_q)
        CALIB: begin
          sum_d = sum_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(M - 1)) begin
            mean_d  = NW'(sum_nx >> LM);
            sum_d   = '0;
            cnt_d   = '0;
            cal_d   = 1'b1;
            state_d = DETECT;
          end
        end
        DETECT: begin
          out_valid_d = 1'b1;
          spike_d     = hit;
          if (hit) begin
            sc_d = &sc_q ? sc_q : sc_q + 16'd1;
            if (R > 0) begin
              state_d = REFRACT;
              cnt_d   = CW'(R);
            end
          end else begin
            mean_d = ema[NW-1:0];
          end
        end
        REFRACT: begin
          out_valid_d = 1'b1;
          spike_d     = 1'b0;
          cnt_d       = cnt_q - CW'(1);
          state_d     = (cnt_q == CW'(1)) ? DETECT : REFRACT;
        end
        default: state_d = CALIB;
      endcase
    end
  end
  // state registers; threshold trails mean by one cycle at full precision
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= CALIB;
      sum_q       <= '0;
      mean_q      <= '0;
      cnt_q       <= '0;
      thr_q       <= '0;
      out_valid_q <= 1'b0;
      spike_q     <= 1'b0;
      cal_q       <= 1'b0;
      sc_q        <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      mean_q      <= mean_d;
      cnt_q       <= cnt_d;
      thr_q       <= TW'(mean_q) * TW'(C);
      out_valid_q <= out_valid_d;
      spike_q     <= spike_d;
      cal_q       <= cal_d;
      sc_q        <= sc_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign spike       = spike_q;
  assign threshold   = thr_q;
  assign calibrated  = cal_q;
  assign spike_count = sc_q;
endmodule

// File: tb/tb_neo_spike_detector.sv
// tb_neo_spike_detector: directed scoreboard bench for neo_spike_detector
module tb_neo_spike_detector;
  localparam int NW = 17;
  localparam int TW = 20;
  logic clk = 1'b0, reset = 1'b0, nv = 1'b0;
  logic signed [NW-1:0] nd = '0;
  logic out_valid, spike, calibrated;
  logic [TW-1:0] threshold;
  logic [15:0] spike_count;
  int total = 0, bad = 0;
  bit exp_q[$];
  neo_spike_detector #(.N(8), .M(8), .C(4), .R(4)) dut (
    .Clk(clk), .reset(reset), .neo_valid(nv), .neo_data(nd),
    .out_valid(out_valid), .spike(spike), .threshold(threshold),
    .calibrated(calibrated), .spike_count(spike_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin bad++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end
  endtask
  task automatic send(input int x, input int e);
    @(negedge clk);
    nv = 1'b1;
    nd = NW'(x);
    if (e >= 0) exp_q.push_back(e != 0);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); nv = 1'b0; end
  endtask
  task automatic do_reset();
    @(negedge clk);
    nv = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_spike", 32'(spike), 0);
    chk("rst_calibrated", 32'(calibrated), 0);
    chk("rst_threshold", 32'(threshold), 0);
    chk("rst_spike_count", 32'(spike_count), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask
  // scoreboard: every out_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    bit e;
    if (!reset && out_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin bad++; $error("FAIL unexpected_out_valid observed=1 expected=0"); end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        assert (spike === e) else begin bad++; $error("FAIL spike observed=%0b expected=%0b", spike, e); end
      end
    end
  end
  initial begin
    do_reset();
    repeat (8) send(100, -1);
    idle(2);
    chk("cal100_calibrated", 32'(calibrated), 1);
    chk("cal100_threshold", 32'(threshold), 400);
    chk("cal100_count", 32'(spike_count), 0);
    send(400, 0);
    send(401, 1);
    idle(2);
    chk("first_spike_count", 32'(spike_count), 1);
    chk("ema_after_400", 32'(threshold), 548);
    repeat (4) send(1000, 0);
    send(1000, 1);
    idle(2);
    chk("second_spike_count", 32'(spike_count), 2);
    chk("refract_mean_held", 32'(threshold), 548);
    chk("spike_held", 32'(spike), 1);
    chk("idle_out_valid", 32'(out_valid), 0);
    do_reset();
    repeat (7) send(100, -1);
    send(-50, -1);
    idle(2);
    chk("neg_cal_calibrated", 32'(calibrated), 1);
    chk("neg_cal_threshold", 32'(threshold), 348);
    do_reset();
    repeat (8) send(100, -1);
    idle(2);
    send(180, 0);
    idle(2);
    chk("ema_180_threshold", 32'(threshold), 440);
    chk("ema_180_count", 32'(spike_count), 0);
    idle(3);
    chk("idle_threshold_held", 32'(threshold), 440);
    send(-5, 0);
    idle(2);
    chk("neg_detect_threshold", 32'(threshold), 384);
    do_reset();
    repeat (5) send(100, -1);
    idle(1);
    chk("partial_cal_calibrated", 32'(calibrated), 0);
    do_reset();
    repeat (8) send(50, -1);
    idle(2);
    chk("recal_calibrated", 32'(calibrated), 1);
    chk("recal_threshold", 32'(threshold), 200);
    chk("recal_count", 32'(spike_count), 0);
    send(201, 1);
    idle(2);
    chk("recal_spike_count", 32'(spike_count), 1);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
